// File: rtl/simon_playback_if.sv
// Playback-side bus of the Simon "computer's turn" sequencer: game-FSM
// request lines, pattern-store read port, LED/status outputs and FSM debug state.
interface simon_playback_if #(
  parameter int AW = 4
);
  // start is a one-cycle request sampled only while the sequencer is idle
  // (busy=0); there is no ready. A request while busy is dropped. The
  // sequencer answers with a one-cycle done pulse, or with nothing if aborted.
  // seq_data must be valid in the same cycle as seq_addr (combinational store).
  logic          start;
  logic [AW:0]   len;
  logic          abort;
  logic [AW-1:0] seq_addr;
  logic [1:0]    seq_data;
  logic [3:0]    led;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;
  logic [1:0]    state;

  modport master (
    output start, len, abort, seq_data,
    input  seq_addr, led, busy, done, step_idx, state
  );

  modport slave (
    input  start, len, abort, seq_data,
    output seq_addr, led, busy, done, step_idx, state
  );
endinterface

// File: rtl/simon_playback_ctrl.sv
// Simon playback sequencer: shows len colours (ON_TICKS lit, GAP_TICKS dark each),
// then pulses done. Optional macro SIMON_PLAY_SPEEDUP_EN shortens on-time for long sequences.
module simon_playback_ctrl #(
  parameter int N         = 16,
  parameter int AW        = 4,
  parameter int ON_TICKS  = 400,
  parameter int GAP_TICKS = 200
) (
  input logic            clk_tick,
  input logic            reset,
  simon_playback_if.slave bus
);

  localparam int TMAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  localparam logic [AW:0]   N_LEN    = (AW + 1)'(N);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_TICKS - 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [AW:0]   len_q;
  logic [AW-1:0] seq_addr;
  logic [AW-1:0] step_idx;
  logic [3:0]    led;
  logic          busy;
  logic          done;
  logic [TW-1:0] on_load;
  logic          last_step;

`ifdef SIMON_PLAY_SPEEDUP_EN
  logic [AW:0] len_m1;
  logic [AW:0] grp;
  logic [1:0]  shift;
  logic [31:0] on_eff;

  // Every four extra steps halve the on-time, at most three times, never below one tick.
  always_comb begin
    len_m1 = len_q - 1'b1;
    grp    = len_m1 >> 2;
    shift  = (grp > (AW + 1)'(3)) ? 2'd3 : grp[1:0];
    on_eff = 32'(ON_TICKS) >> shift;
    if (on_eff == 32'd0) begin
      on_eff = 32'd1;
    end
    on_load = TW'(on_eff - 32'd1);
  end
`else
  assign on_load = TW'(ON_TICKS - 1);
`endif

  assign last_step = ({1'b0, step_idx} == (len_q - 1'b1));

  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      len_q    <= '0;
      seq_addr <= '0;
      step_idx <= '0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over any timer expiry and never produces done.
      if (bus.abort && (state != IDLE)) begin
        state <= IDLE;
        led   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              if (bus.len == '0) begin
                done <= 1'b1;
              end else begin
                len_q    <= (bus.len > N_LEN) ? N_LEN : bus.len;
                seq_addr <= '0;
                step_idx <= '0;
                busy     <= 1'b1;
                state    <= FETCH;
              end
            end
          end
          FETCH: begin
            led   <= 4'b0001 << bus.seq_data;
            timer <= on_load;
            state <= SHOW;
          end
          SHOW: begin
            if (timer == '0) begin
              led   <= '0;
              timer <= GAP_LOAD;
              state <= GAP;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          GAP: begin
            if (timer == '0) begin
              if (last_step) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                step_idx <= step_idx + 1'b1;
                seq_addr <= seq_addr + 1'b1;
                state    <= FETCH;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.seq_addr = seq_addr;
  assign bus.step_idx = step_idx;
  assign bus.led      = led;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.state    = state;

endmodule
